// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants for the unified memory arbiter.
package unified_mem_arbiter_pkg;

  localparam int unsigned ISIZE    = 16;
  localparam int unsigned DSIZE    = 16;
  localparam int unsigned STREAK_W = 4;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_streak_counter.sv
// Starvation guard: counts consecutive contested data wins and forces a fetch grant.
module arb_streak_counter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic if_gnt,
  input  logic dm_gnt,
  output logic force_if_c
);

  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;

  // Next streak: clear when fetch wins or stops asking, bump on a contested data win
  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !if_req) begin
      streak_d = '0;
    end else if (dm_gnt && (streak_q < STREAK_W'(MAX_STREAK))) begin
      streak_d = streak_q + STREAK_W'(1);
    end
  end

  // Streak register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  assign force_if_c = (streak_q == STREAK_W'(MAX_STREAK));

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and data ports and routes read data back.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned AW         = ISIZE,
  parameter int unsigned DW         = DSIZE,
  parameter int unsigned MAX_STREAK = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DW-1:0]    if_rdata,
  output logic             stall_if,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [AW-1:0]    dm_addr,
  input  logic [DW-1:0]    dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [DW-1:0]    dm_rdata,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_din,
  input  logic [DW-1:0]    mem_dout,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic             force_if_c;
  logic             rtag_v_q, rtag_v_d;
  logic             rtag_own_q, rtag_own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  arb_streak_counter #(
    .MAX_STREAK (MAX_STREAK)
  ) u_streak (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_gnt     (if_gnt),
    .dm_gnt     (dm_gnt),
    .force_if_c (force_if_c)
  );

  // Grant selection and memory drive; data wins unless fetch has starved too long
  always_comb begin
    dm_gnt   = 1'b0;
    if_gnt   = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (!rst) begin
      dm_gnt = dm_req && !(if_req && force_if_c);
      if_gnt = if_req && !dm_gnt;
    end
    stall_if = if_req && !if_gnt;
    if (dm_gnt) begin
      mem_wen  = dm_we;
      mem_addr = dm_addr;
      mem_din  = dm_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Next read tag and saturating conflict count
  always_comb begin
    rtag_v_d   = if_gnt || (dm_gnt && !dm_we);
    rtag_own_d = dm_gnt ? OWN_DM : OWN_IF;
    cnt_d      = cnt_q;
    if (if_req && dm_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Tag and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rtag_v_q   <= 1'b0;
      rtag_own_q <= OWN_IF;
      cnt_q      <= '0;
    end else begin
      rtag_v_q   <= rtag_v_d;
      rtag_own_q <= rtag_own_d;
      cnt_q      <= cnt_d;
    end
  end

  // Return path: steer the memory word to whoever owned last cycle's read
  always_comb begin
    if_rvalid = rtag_v_q && (rtag_own_q == OWN_IF);
    dm_rvalid = rtag_v_q && (rtag_own_q == OWN_DM);
    if_rdata  = if_rvalid ? mem_dout : '0;
    dm_rdata  = dm_rvalid ? mem_dout : '0;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: behavioural model of arbitration plus directed literal checks.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        if_gnt, if_rvalid, stall_if, dm_gnt, dm_rvalid, mem_wen;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_din, conflict_cnt;
  logic [15:0] mem_dout = '0;
  // second instance with a narrow counter, sharing inputs and memory data
  logic        b_if_gnt, b_if_rvalid, b_stall_if, b_dm_gnt, b_dm_rvalid, b_mem_wen;
  logic [15:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_din;
  logic [3:0]  b_conflict_cnt;

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(.AW(16), .DW(16), .MAX_STREAK(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .stall_if(stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .conflict_cnt(conflict_cnt));

  unified_mem_arbiter #(.AW(16), .DW(16), .MAX_STREAK(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .stall_if(b_stall_if),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_wen(b_mem_wen), .mem_addr(b_mem_addr), .mem_din(b_mem_din),
    .mem_dout(mem_dout), .conflict_cnt(b_conflict_cnt));

  always #5 clk = ~clk;

  // Environment memory: single port, one-cycle read latency
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_wen) mem[mem_addr[7:0]] <= mem_din;
    mem_dout <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] ref_mem [0:255];
  int          waited;      // consecutive cycles fetch lost to data
  bit          pend_v;      // a read is returning this cycle
  bit          pend_dm;     // it belongs to the data port
  logic [15:0] pend_data;
  longint      n_conflict;

  // Compare DUT against model at every falling edge, then advance the model
  always @(negedge clk) begin
    bit          e_dg, e_ig;
    logic [15:0] e_addr;
    if (rst) begin
      waited = 0; pend_v = 0; pend_dm = 0; pend_data = '0; n_conflict = 0;
      chk("rst_if_gnt", if_gnt, 0);
      chk("rst_dm_gnt", dm_gnt, 0);
      chk("rst_mem_wen", mem_wen, 0);
      chk("rst_stall", stall_if, if_req);
      chk("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
      chk("rst_rdata", {if_rdata, dm_rdata}, 0);
      chk("rst_cnt", conflict_cnt, 0);
    end else begin
      e_dg   = dm_req && !(if_req && waited >= 3);
      e_ig   = if_req && !e_dg;
      e_addr = e_dg ? dm_addr : (e_ig ? if_addr : 16'h0);
      chk("dm_gnt", dm_gnt, e_dg);
      chk("if_gnt", if_gnt, e_ig);
      chk("stall_if", stall_if, if_req && !e_ig);
      chk("mem_wen", mem_wen, e_dg && dm_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_dg) chk("mem_din", mem_din, dm_wdata);
      else if (!e_ig) chk("mem_din_idle", mem_din, 0);
      chk("if_rvalid", if_rvalid, pend_v && !pend_dm);
      chk("dm_rvalid", dm_rvalid, pend_v && pend_dm);
      chk("if_rdata", if_rdata, (pend_v && !pend_dm) ? pend_data : 16'h0);
      chk("dm_rdata", dm_rdata, (pend_v && pend_dm) ? pend_data : 16'h0);
      chk("conflict_cnt", conflict_cnt, (n_conflict > 65535) ? 65535 : n_conflict);
      chk("conflict_cnt_sat", b_conflict_cnt, (n_conflict > 15) ? 15 : n_conflict);
      // advance to the next cycle
      pend_v    = e_ig || (e_dg && !dm_we);
      pend_dm   = e_dg;
      pend_data = ref_mem[e_addr[7:0]];
      if (e_dg && dm_we) ref_mem[dm_addr[7:0]] = dm_wdata;
      if (e_ig || !if_req) waited = 0;
      else if (e_dg) waited++;
      if (if_req && dm_req) n_conflict++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit ir, input logic [15:0] ia, input bit dr, input bit we,
                        input logic [15:0] da, input logic [15:0] wd);
    if_req = ir; if_addr = ia; dm_req = dr; dm_we = we; dm_addr = da; dm_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[3] = 16'h1234; ref_mem[3] = 16'h1234;
    mem[5] = 16'h5555; ref_mem[5] = 16'h5555;
    mem[6] = 16'h6666; ref_mem[6] = 16'h6666;
    mem[7] = 16'h7777; ref_mem[7] = 16'h7777;
    #2;
    chk("init_rst_gnt", {if_gnt, dm_gnt}, 0);
    chk("init_rst_cnt", conflict_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    next_cycle();

    // fetch only
    set_in(1, 16'h0003, 0, 0, 0, 0); #3;
    chk("t1_if_gnt", if_gnt, 1);
    chk("t1_stall", stall_if, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0); #3;
    chk("t1_if_rvalid", if_rvalid, 1);
    chk("t1_if_rdata", if_rdata, 16'h1234);
    chk("t1_dm_rvalid", dm_rvalid, 0);
    next_cycle();

    // contested reads: data, data, data, fetch, data
    for (int c = 0; c < 5; c++) begin
      set_in(1, 16'(8'h40 + c), 1, 0, 16'(8'h50 + c), 0); #3;
      chk("t2_dm_gnt", dm_gnt, (c == 3) ? 0 : 1);
      chk("t2_if_gnt", if_gnt, (c == 3) ? 1 : 0);
      chk("t2_stall", stall_if, (c == 3) ? 0 : 1);
      if (c > 0) chk("t2_owner", {if_rvalid, dm_rvalid}, (c == 4) ? 2'b10 : 2'b01);
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    next_cycle();

    // contested write, then read back
    set_in(1, 16'h0020, 1, 1, 16'h0010, 16'hBEEF); #3;
    chk("t3_mem_wen", mem_wen, 1);
    chk("t3_if_gnt", if_gnt, 0);
    next_cycle();
    set_in(0, 0, 1, 0, 16'h0010, 0); #3;
    chk("t3_no_rvalid", {if_rvalid, dm_rvalid}, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0); #3;
    chk("t3_dm_rdata", dm_rdata, 16'hBEEF);
    next_cycle();

    // alternating owners
    set_in(0, 0, 1, 0, 16'h0005, 0); next_cycle();
    set_in(1, 16'h0006, 0, 0, 0, 0); #3;
    chk("t6_dm_rdata", dm_rdata, 16'h5555);
    next_cycle();
    set_in(0, 0, 1, 0, 16'h0007, 0); #3;
    chk("t6_if_rdata", if_rdata, 16'h6666);
    chk("t6_if_only", dm_rvalid, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0); #3;
    chk("t6_dm_rdata2", dm_rdata, 16'h7777);
    next_cycle();

    // async reset with a read in flight
    set_in(0, 0, 1, 0, 16'h0021, 0); next_cycle();
    set_in(0, 0, 0, 0, 0, 0);
    chk("t4_pre_rvalid", dm_rvalid, 1);
    #1 rst = 1'b1; #1;
    chk("t4_dm_rvalid", dm_rvalid, 0);
    chk("t4_cnt", conflict_cnt, 0);
    next_cycle(); next_cycle();
    #1 rst = 1'b0;
    next_cycle(); #3;
    chk("t4_quiet", {if_rvalid, dm_rvalid}, 0);
    next_cycle();

    // saturation of the narrow counter
    for (int c = 0; c < 20; c++) begin
      set_in(1, 16'($urandom_range(0, 255)), 1, 0, 16'($urandom_range(0, 255)), 0);
      next_cycle();
      if (c == 14) chk("t5_cnt15", b_conflict_cnt, 4'hF);
    end
    chk("t5_cnt_hold", b_conflict_cnt, 4'hF);
    chk("t5_wide_cnt", conflict_cnt, 16'd20);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      set_in(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 255)),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
             16'($urandom_range(0, 255)), 16'($urandom));
      next_cycle();
    end
    set_in(0, 0, 0, 0, 0, 0);
    next_cycle(); next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
